// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared types for the button debouncer.
//   - debounce_state_t : the two stable levels (S_LOW, S_HIGH) and their
//                        qualification states (S_RISE, S_FALL).
//   - idle_state()     : stable state corresponding to a given level, used to
//                        pick the reset state from RESET_VALUE.
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } debounce_state_t;

    function automatic debounce_state_t idle_state(input logic level);
        return level ? S_HIGH : S_LOW;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// ---------------------------------------------------------------------------
// synchronizer
//   Multi-flop synchronizer for a single asynchronous bit. Generic so that
//   other async-input blocks can reuse it.
//   Parameters:
//     STAGES      number of flops in series (>= 2)
//     RESET_VALUE level every flop takes while in reset
//   Ports:
//     clk  in  clock
//     rst  in  asynchronous active-low reset
//     d    in  raw asynchronous input
//     q    out synchronized output (last flop of the chain)
// ---------------------------------------------------------------------------
module synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // d enters at bit 0 and shifts toward bit STAGES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Turns a raw, bouncing asynchronous input into a clean registered level
//   synchronous to clk. A new level is accepted only after the synchronized
//   input has held it for STABLE_CYCLES+1 consecutive edges; anything shorter
//   is treated as a glitch and out keeps its last accepted level.
//   Parameters:
//     SYNC_STAGES   synchronizer depth (>= 2)
//     STABLE_CYCLES cycles a new level must hold inside a check state (>= 1)
//     RESET_VALUE   level of the synchronizer and out while in reset
//   Ports:
//     clk       in  clock
//     rst       in  asynchronous active-low reset
//     in        in  raw asynchronous input
//     out       out debounced level (registered)
//     bouncing  out high while a candidate transition is being qualified
// ---------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic bouncing
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    logic            in_sync;
    debounce_state_t state;
    debounce_state_t state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (in_sync)
    );

    // Next-state logic. The counter only advances inside a check state and
    // is cleared on every state change, so it tops out at STABLE_CYCLES-1.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            S_LOW: begin
                if (in_sync) begin
                    state_next = S_RISE;
                    count_next = '0;
                end
            end
            S_RISE: begin
                if (!in_sync) begin
                    state_next = S_LOW;
                    count_next = '0;
                end else if (count == LAST_COUNT) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_HIGH: begin
                if (!in_sync) begin
                    state_next = S_FALL;
                    count_next = '0;
                end
            end
            S_FALL: begin
                if (in_sync) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end else if (count == LAST_COUNT) begin
                    state_next = S_LOW;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = S_LOW;
                count_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= idle_state(RESET_VALUE);
            count    <= '0;
            out      <= RESET_VALUE;
            bouncing <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            out      <= (state_next == S_HIGH) || (state_next == S_FALL);
            bouncing <= (state_next == S_RISE) || (state_next == S_FALL);
        end
    end

endmodule
